ifu_prefetch_queue: RTL and testbench

//  Instruction fetch unit with a parametrised prefetch queue. Issues sequential
//  AXI-style read requests from an internal fetch PC and buffers the returned

---
 rtl/ifu_prefetch_queue.sv | 190 +++++++++++++++++++
 tb/tb_ifu_prefetch_queue.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_prefetch_queue.sv
// Instruction fetch unit: single-outstanding AXI-style read sequencer feeding a prefetch FIFO.
// Define IFU_BYPASS_EN to forward a response straight to decode when the queue is empty.
module ifu_prefetch_queue #(
   parameter int unsigned       ADDR_W     = 32,
   parameter int unsigned       BUS_DATA_W = 64,
   parameter int unsigned       FIFO_DEPTH = 4,
   parameter logic [ADDR_W-1:0] RESET_PC   = 32'h8000_0000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  redirect_valid,
   input  logic [ADDR_W-1:0]     redirect_pc,
   input  logic                  io_master_arready,
   output logic                  io_master_arvalid,
   output logic [ADDR_W-1:0]     io_master_araddr,
   output logic                  io_master_rready,
   input  logic                  io_master_rvalid,
   input  logic [1:0]            io_master_rresp,
   input  logic [BUS_DATA_W-1:0] io_master_rdata,
   output logic                  inst_valid,
   input  logic                  inst_ready,
   output logic [31:0]           inst,
   output logic [ADDR_W-1:0]     inst_pc,
   output logic                  inst_err
);
   localparam int unsigned      PTR_W   = $clog2(FIFO_DEPTH);
   localparam int unsigned      CNT_W   = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ADDR  = 2'd1,
      S_DATA  = 2'd2,
      S_DRAIN = 2'd3
   } state_e;

   state_e            state_q;
   logic [ADDR_W-1:0] fetch_pc_q;
   logic [ADDR_W-1:0] araddr_q;
   logic              arvalid_q;
   logic              rready_q;
   logic              flush_q;

   logic [31:0]           q_inst_q [FIFO_DEPTH];
   logic [ADDR_W-1:0]     q_pc_q   [FIFO_DEPTH];
   logic [FIFO_DEPTH-1:0] q_err_q;
   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]      count_q, count_d;
   logic                  valid_q;

   logic [31:0] rsp_inst_s;
   logic        rsp_err_s;
   logic        ar_hs_s;
   logic        accept_s;
   logic        wr_s;
   logic        pop_s;

   if (BUS_DATA_W == 64) begin : g_lane64
      assign rsp_inst_s = araddr_q[2] ? io_master_rdata[63:32] : io_master_rdata[31:0];
   end else begin : g_lane32
      assign rsp_inst_s = io_master_rdata[31:0];
   end

   assign rsp_err_s = (io_master_rresp != 2'b00);
   assign ar_hs_s   = arvalid_q && io_master_arready;
   // A response is kept only in DATA without a redirect; DRAIN and redirect cycles drop it.
   assign accept_s  = (state_q == S_DATA) && io_master_rvalid && !redirect_valid;
   assign pop_s     = valid_q && inst_ready;

`ifdef IFU_BYPASS_EN
   logic byp_s;
   assign byp_s      = accept_s && (count_q == {CNT_W{1'b0}});
   assign wr_s       = accept_s && !(byp_s && inst_ready);
   assign inst_valid = valid_q || byp_s;
   assign inst       = byp_s ? rsp_inst_s : q_inst_q[rd_ptr_q];
   assign inst_pc    = byp_s ? araddr_q   : q_pc_q[rd_ptr_q];
   assign inst_err   = byp_s ? rsp_err_s  : q_err_q[rd_ptr_q];
`else
   assign wr_s       = accept_s;
   assign inst_valid = valid_q;
   assign inst       = q_inst_q[rd_ptr_q];
   assign inst_pc    = q_pc_q[rd_ptr_q];
   assign inst_err   = q_err_q[rd_ptr_q];
`endif

   assign io_master_arvalid = arvalid_q;
   assign io_master_araddr  = araddr_q;
   assign io_master_rready  = rready_q;

   // Queue pointer and occupancy next state; redirect empties the queue and ignores a pop.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (redirect_valid) begin
         wr_ptr_d = {PTR_W{1'b0}};
         rd_ptr_d = {PTR_W{1'b0}};
         count_d  = {CNT_W{1'b0}};
      end else begin
         if (wr_s) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         else      wr_ptr_d = wr_ptr_q;
         if (pop_s) rd_ptr_d = rd_ptr_q + PTR_W'(1);
         else       rd_ptr_d = rd_ptr_q;
         case ({wr_s, pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // Queue control registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= {PTR_W{1'b0}};
         rd_ptr_q <= {PTR_W{1'b0}};
         count_q  <= {CNT_W{1'b0}};
         valid_q  <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         valid_q  <= (count_d != {CNT_W{1'b0}});
      end
   end

   // Queue storage; contents are don't-care until written.
   always_ff @(posedge clk) begin
      if (wr_s) begin
         q_inst_q[wr_ptr_q] <= rsp_inst_s;
         q_pc_q[wr_ptr_q]   <= araddr_q;
         q_err_q[wr_ptr_q]  <= rsp_err_s;
      end
   end

   // Fetch sequencer: issue only with a free slot, hold AR until accepted, drain flushed reads.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         fetch_pc_q <= RESET_PC;
         araddr_q   <= RESET_PC;
         arvalid_q  <= 1'b0;
         rready_q   <= 1'b0;
         flush_q    <= 1'b0;
      end else begin
         if (redirect_valid)  fetch_pc_q <= redirect_pc;
         else if (accept_s)   fetch_pc_q <= fetch_pc_q + ADDR_W'(4);
         case (state_q)
            S_IDLE: begin
               if (!redirect_valid && (count_q < DEPTH_C)) begin
                  state_q   <= S_ADDR;
                  arvalid_q <= 1'b1;
                  araddr_q  <= fetch_pc_q;
               end
            end
            S_ADDR: begin
               if (ar_hs_s) begin
                  arvalid_q <= 1'b0;
                  rready_q  <= 1'b1;
                  flush_q   <= 1'b0;
                  state_q   <= (flush_q || redirect_valid) ? S_DRAIN : S_DATA;
               end else if (redirect_valid) begin
                  flush_q <= 1'b1;
               end
            end
            S_DATA: begin
               if (io_master_rvalid) begin
                  state_q  <= S_IDLE;
                  rready_q <= 1'b0;
               end else if (redirect_valid) begin
                  state_q <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               if (io_master_rvalid) begin
                  state_q  <= S_IDLE;
                  rready_q <= 1'b0;
               end
            end
            default: begin
               state_q   <= S_IDLE;
               arvalid_q <= 1'b0;
               rready_q  <= 1'b0;
               flush_q   <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_ifu_prefetch_queue.sv
// Self-checking bench for ifu_prefetch_queue: directed sequences, a lane/error vector table,
// and randomized traffic checked against a transaction-level stream/occupancy model.
`timescale 1ns/1ps
module tb_ifu_prefetch_queue;
   localparam int DEPTH = 4;
`ifdef IFU_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        arready, arvalid, rready, rvalid;
   logic [31:0] araddr;
   logic [1:0]  rresp;
   logic [63:0] rdata;
   logic        inst_valid, inst_ready, inst_err;
   logic [31:0] inst, inst_pc;

   always #5 clk = ~clk;

   ifu_prefetch_queue dut (
      .clk(clk), .rst(rst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .io_master_arready(arready), .io_master_arvalid(arvalid), .io_master_araddr(araddr),
      .io_master_rready(rready), .io_master_rvalid(rvalid), .io_master_rresp(rresp),
      .io_master_rdata(rdata), .inst_valid(inst_valid), .inst_ready(inst_ready),
      .inst(inst), .inst_pc(inst_pc), .inst_err(inst_err)
   );

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // memory model and stimulus controls
   bit          mem_busy;
   logic [31:0] mem_addr;
   int          mem_wait;
   int          ar_mode;            // 0 always ready, 1 random, 2 held low
   int          lat_min, lat_max;
   bit          fix_en;
   logic [63:0] fix_rdata;
   logic [1:0]  fix_rresp;
   bit          rnd_err;
   logic [31:0] err_addr;

   // per-cycle observations
   bit          hs_ar, hs_r, last_dec;
   logic [31:0] hs_ar_addr, last_inst, last_pc;
   logic        last_err;
   bit          prev_stall, prev_redirect, prev_arvalid;
   logic [31:0] prev_araddr;

   // reference model
   logic [31:0] exp_pc;
   int          occ;
   bit          taint;
   int          n_deliv;
   logic [31:0] ar_log[$];
   logic [31:0] dec_log[$];
   logic [31:0] err_log[$];
   logic [31:0] kept_iv_log[$];

   function automatic logic [31:0] word_of(input logic [31:0] a);
      return {a[15:0] ^ 16'hC3A5, ~a[15:0]};
   endfunction

   function automatic logic [63:0] rdata_of(input logic [31:0] a);
      return {word_of({a[31:3], 3'b100}), word_of({a[31:3], 3'b000})};
   endfunction

   function automatic logic [1:0] rresp_of(input logic [31:0] a);
      if (a == err_addr) return 2'b10;
      if (rnd_err && a[6:2] == 5'd7) return 2'b10;
      if (rnd_err && a[6:2] == 5'd13) return 2'b01;
      return 2'b00;
   endfunction

   function automatic logic [31:0] q_at(input logic [31:0] q[$], input int i);
      return (i < q.size()) ? q[i] : 32'hDEAD_DEAD;
   endfunction

   task automatic drive();
      if (hs_r) begin
         rvalid   = 1'b0;
         mem_busy = 1'b0;
      end
      if (hs_ar) begin
         mem_busy = 1'b1;
         mem_addr = hs_ar_addr;
         mem_wait = $urandom_range(lat_max, lat_min);
      end
      if (mem_busy && !rvalid) begin
         if (mem_wait == 0) begin
            rvalid = 1'b1;
            rdata  = fix_en ? fix_rdata : rdata_of(mem_addr);
            rresp  = fix_en ? fix_rresp : rresp_of(mem_addr);
         end else begin
            mem_wait--;
         end
      end
      case (ar_mode)
         0:       arready = 1'b1;
         1:       arready = ($urandom_range(3, 0) != 0);
         default: arready = 1'b0;
      endcase
   endtask

   task automatic sample();
      bit kept;
      bit dec;
      hs_ar      = arvalid && arready;
      hs_r       = rvalid && rready;
      hs_ar_addr = araddr;
      if (prev_stall) begin
         chk("ar_hold_valid", 64'(arvalid), 64'(1));
         chk("ar_hold_addr", 64'(araddr), 64'(prev_araddr));
      end
      if (prev_redirect) chk("flush_empty", 64'(inst_valid), 64'(0));
      if (arvalid && !prev_arvalid) taint = 1'b0;
      if (redirect_valid && (arvalid || mem_busy)) taint = 1'b1;
      kept = hs_r && !taint && !redirect_valid;
      chk("inst_valid", 64'(inst_valid), 64'((occ != 0) || (BYP && kept)));
      if (kept) kept_iv_log.push_back(32'(inst_valid));
      dec = inst_valid && inst_ready && !redirect_valid;
      last_dec = dec;
      if (dec) begin
         if (!fix_en) begin
            chk("inst_pc", 64'(inst_pc), 64'(exp_pc));
            chk("inst", 64'(inst), 64'(word_of(exp_pc)));
            chk("inst_err", 64'(inst_err), 64'(rresp_of(exp_pc) != 2'b00));
         end
         last_inst = inst;
         last_pc   = inst_pc;
         last_err  = inst_err;
         dec_log.push_back(inst_pc);
         err_log.push_back(32'(inst_err));
         exp_pc = exp_pc + 32'd4;
         n_deliv++;
      end
      if (redirect_valid) begin
         exp_pc = redirect_pc;
         occ    = 0;
      end else begin
         occ = occ + int'(kept) - int'(dec);
         if (kept) chk("occupancy_bound", 64'(occ <= DEPTH), 64'(1));
      end
      if (hs_ar) ar_log.push_back(araddr);
      prev_stall    = arvalid && !arready;
      prev_araddr   = araddr;
      prev_redirect = redirect_valid;
      prev_arvalid  = arvalid;
   endtask

   task automatic step();
      drive();
      @(negedge clk);
      sample();
      @(posedge clk);
      #1;
   endtask

   task automatic step_until_ar(input int limit, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < limit && !ok; i++) begin
         step();
         if (hs_ar) ok = 1'b1;
      end
   endtask

   task automatic do_reset();
      rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0;
      rvalid = 1'b0; rresp = 2'b00; rdata = 64'h0; arready = 1'b0; inst_ready = 1'b0;
      mem_busy = 1'b0; mem_wait = 0; hs_ar = 1'b0; hs_r = 1'b0; last_dec = 1'b0;
      prev_stall = 1'b0; prev_redirect = 1'b0; prev_arvalid = 1'b0;
      taint = 1'b0; occ = 0; exp_pc = 32'h8000_0000;
      ar_log.delete(); dec_log.delete(); err_log.delete(); kept_iv_log.delete();
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_arvalid", 64'(arvalid), 64'(0));
      chk("rst_rready", 64'(rready), 64'(0));
      chk("rst_inst_valid", 64'(inst_valid), 64'(0));
      rst = 1'b0;
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic [31:0] pc;
      logic [63:0] rdata;
      logic [1:0]  rresp;
      logic [31:0] exp_inst;
      logic        exp_err;
   } vec_t;
   vec_t tbl[6];

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin : main
      bit ok;
      bit seen;
      logic [31:0] tmp;
      tbl[0] = '{32'h8000_0004, 64'hAAAA_AAAA_5555_5555, 2'b00, 32'hAAAA_AAAA, 1'b0};
      tbl[1] = '{32'h8000_0000, 64'hAAAA_AAAA_5555_5555, 2'b00, 32'h5555_5555, 1'b0};
      tbl[2] = '{32'h8000_0008, 64'h1234_5678_9ABC_DEF0, 2'b10, 32'h9ABC_DEF0, 1'b1};
      tbl[3] = '{32'h8000_000C, 64'h1234_5678_9ABC_DEF0, 2'b01, 32'h1234_5678, 1'b1};
      tbl[4] = '{32'hFFFF_FFFC, 64'hDEAD_BEEF_0BAD_F00D, 2'b00, 32'hDEAD_BEEF, 1'b0};
      tbl[5] = '{32'h0000_0010, 64'hCAFE_0000_0000_CAFE, 2'b11, 32'h0000_CAFE, 1'b1};
      ar_mode = 0; lat_min = 0; lat_max = 0; fix_en = 1'b0; rnd_err = 1'b0;
      err_addr = 32'h0000_0001; n_deliv = 0;

      // sequential fetch with a 1-cycle memory
      do_reset();
      inst_ready = 1'b1;
      chk("t1_first_arvalid", 64'(arvalid), 64'(1));
      chk("t1_first_araddr", 64'(araddr), 64'(32'h8000_0000));
      repeat (12) step();
      chk("t1_ar0", 64'(q_at(ar_log, 0)), 64'(32'h8000_0000));
      chk("t1_ar1", 64'(q_at(ar_log, 1)), 64'(32'h8000_0004));
      chk("t1_ar2", 64'(q_at(ar_log, 2)), 64'(32'h8000_0008));
      chk("t1_pc2", 64'(q_at(dec_log, 2)), 64'(32'h8000_0008));

      // lane select and error flag vectors
      do_reset();
      inst_ready = 1'b1;
      fix_en = 1'b1;
      for (int v = 0; v < 6; v++) begin
         fix_rdata = tbl[v].rdata;
         fix_rresp = tbl[v].rresp;
         redirect_valid = 1'b1; redirect_pc = tbl[v].pc;
         step();
         redirect_valid = 1'b0;
         ok = 1'b0;
         for (int i = 0; i < 30 && !ok; i++) begin
            step();
            ok = last_dec;
         end
         chk("tbl_delivered", 64'(ok), 64'(1));
         chk("tbl_inst", 64'(last_inst), 64'(tbl[v].exp_inst));
         chk("tbl_pc", 64'(last_pc), 64'(tbl[v].pc));
         chk("tbl_err", 64'(last_err), 64'(tbl[v].exp_err));
      end
      fix_en = 1'b0;

      // back-pressure: queue fills, fetch stops, resumes on pop
      do_reset();
      repeat (40) step();
      chk("t3_ar_count", 64'(ar_log.size()), 64'(DEPTH));
      chk("t3_arvalid_idle", 64'(arvalid), 64'(0));
      chk("t3_inst_valid", 64'(inst_valid), 64'(1));
      ar_log.delete();
      inst_ready = 1'b1;
      repeat (20) step();
      chk("t3_resume_ar", 64'(q_at(ar_log, 0)), 64'(32'h8000_0010));
      chk("t3_pc4", 64'(q_at(dec_log, 4)), 64'(32'h8000_0010));

      // redirect while waiting for data
      do_reset();
      inst_ready = 1'b1; lat_min = 2; lat_max = 2;
      step_until_ar(10, ok);
      chk("t4_first_ar", 64'(ok), 64'(1));
      redirect_valid = 1'b1; redirect_pc = 32'h8000_0100;
      step();
      redirect_valid = 1'b0;
      ar_log.delete();
      seen = 1'b0; ok = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
         step();
         if (inst_valid) seen = 1'b1;
         ok = hs_ar;
      end
      chk("t4_dropped", 64'(seen), 64'(0));
      chk("t4_next_ar", 64'(q_at(ar_log, 0)), 64'(32'h8000_0100));
      repeat (15) step();
      chk("t4_first_pc", 64'(q_at(dec_log, 0)), 64'(32'h8000_0100));
      lat_min = 0; lat_max = 0;

      // redirect while AR is stalled
      do_reset();
      inst_ready = 1'b1; ar_mode = 2;
      step();
      redirect_valid = 1'b1; redirect_pc = 32'h8000_0200;
      step();
      redirect_valid = 1'b0;
      repeat (2) step();
      chk("t5_hold_valid", 64'(arvalid), 64'(1));
      chk("t5_hold_addr", 64'(araddr), 64'(32'h8000_0000));
      ar_mode = 0;
      repeat (20) step();
      chk("t5_ar0", 64'(q_at(ar_log, 0)), 64'(32'h8000_0000));
      chk("t5_ar1", 64'(q_at(ar_log, 1)), 64'(32'h8000_0200));
      chk("t5_first_pc", 64'(q_at(dec_log, 0)), 64'(32'h8000_0200));

      // error response does not stall fetch
      do_reset();
      inst_ready = 1'b1; err_addr = 32'h8000_0008;
      repeat (20) step();
      chk("t6_bypass_iv", 64'(q_at(kept_iv_log, 0)), 64'(BYP));
      chk("t6_err_pc", 64'(q_at(dec_log, 2)), 64'(32'h8000_0008));
      chk("t6_err_flag", 64'(q_at(err_log, 2)), 64'(1));
      chk("t6_next_pc", 64'(q_at(dec_log, 3)), 64'(32'h8000_000C));
      chk("t6_next_err", 64'(q_at(err_log, 3)), 64'(0));
      err_addr = 32'h0000_0001;

      // randomized traffic against the stream model
      do_reset();
      ar_mode = 1; lat_min = 0; lat_max = 3; rnd_err = 1'b1; n_deliv = 0;
      for (int c = 0; c < 3000; c++) begin
         inst_ready = ($urandom_range(9, 0) < 6);
         if ($urandom_range(99, 0) < 3) begin
            tmp = $urandom();
            tmp[1:0] = 2'b00;
            if ($urandom_range(3, 0) == 0) tmp = 32'hFFFF_FFF0;
            redirect_valid = 1'b1;
            redirect_pc = tmp;
         end else begin
            redirect_valid = 1'b0;
         end
         step();
      end
      redirect_valid = 1'b0;
      chk("rand_liveness", 64'(n_deliv > 200), 64'(1));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
